// File: rtl/usb_tx_pkt_pkg.sv
// Shared USB TX definitions: PID codes, CRC16 constants, packet-builder state encoding.
package usb_tx_pkt_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PID    = 3'd1,
        ST_DATA   = 3'd2,
        ST_FETCH  = 3'd3,
        ST_CRC_LO = 3'd4,
        ST_CRC_HI = 3'd5
    } tx_state_t;

    // DATA0/DATA1/DATA2/MDATA all share the low PID bits 2'b11.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/usb_tx_pkt_if.sv
// Packet request / endpoint buffer / low-level TX handshake bundle for the USB packet builder.
interface usb_tx_pkt_if #(
    parameter int LEN_W = 10
);
    logic             pkt_start;
    logic             pkt_done;
    logic [3:0]       pkt_pid;
    logic [LEN_W-1:0] pkt_len;
    logic [7:0]       pkt_data;
    logic             pkt_data_ack;
    logic [7:0]       ll_data;
    logic             ll_valid;
    logic             ll_last;
    logic             ll_ack;
    logic             busy;

    modport slave (
        input  pkt_start, pkt_pid, pkt_len, pkt_data, ll_ack,
        output pkt_done, pkt_data_ack, ll_data, ll_valid, ll_last, busy
    );

    modport master (
        output pkt_start, pkt_pid, pkt_len, pkt_data, ll_ack,
        input  pkt_done, pkt_data_ack, ll_data, ll_valid, ll_last, busy
    );
endinterface

// File: rtl/usb_tx_pkt_crc16.sv
// Byte-wide combinational USB CRC16 update (reflected 0x8005, LSB first); shared with the RX checker.
module usb_tx_pkt_crc16
    import usb_tx_pkt_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);
    logic [15:0] w_c;

    always_comb begin
        w_c = i_crc ^ {8'h00, i_data};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC16_POLY_REF) : (w_c >> 1);
        end
        o_crc = w_c;
    end
endmodule

// File: rtl/usb_tx_pkt.sv
// Device-side USB packet builder: emits PID, optional payload and inverted CRC16 to the low-level TX.
module usb_tx_pkt
    import usb_tx_pkt_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    usb_tx_pkt_if.slave  tx
);
    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [3:0]       r_pid;
    logic [LEN_W-1:0] r_cnt;
    logic [15:0]      r_crc;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_is_data;
    logic [15:0]      w_crc_nxt;

    assign w_is_data = is_data_pid(r_pid);

    usb_tx_pkt_crc16 u_crc16 (
        .i_crc  (r_crc),
        .i_data (tx.pkt_data),
        .o_crc  (w_crc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pid  <= 4'h0;
            r_cnt  <= '0;
            r_crc  <= CRC16_INIT;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (r_state == ST_IDLE && tx.pkt_start) begin
                r_pid <= tx.pkt_pid;
                r_cnt <= tx.pkt_len;
                r_crc <= CRC16_INIT;
            end else if (r_state == ST_DATA && tx.ll_ack) begin
                r_crc <= w_crc_nxt;
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end

    // ll_valid is a pure function of state, so ll_ack is only acted on in states that drive it.
    always_comb begin
        w_state_nxt     = r_state;
        w_done_nxt      = 1'b0;
        tx.ll_valid     = 1'b0;
        tx.ll_last      = 1'b0;
        tx.ll_data      = 8'h00;
        tx.pkt_data_ack = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx.pkt_start) w_state_nxt = ST_PID;
            end
            ST_PID: begin
                tx.ll_valid = 1'b1;
                tx.ll_data  = {~r_pid, r_pid};
                tx.ll_last  = ~w_is_data;
                if (tx.ll_ack) begin
                    if (w_is_data) begin
                        w_state_nxt = (r_cnt != '0) ? ST_DATA : ST_CRC_LO;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                tx.ll_valid = 1'b1;
                tx.ll_data  = tx.pkt_data;
                if (tx.ll_ack) begin
                    tx.pkt_data_ack = 1'b1;
                    w_state_nxt     = (r_cnt == LEN_W'(1)) ? ST_CRC_LO : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_DATA;
            end
            ST_CRC_LO: begin
                tx.ll_valid = 1'b1;
                tx.ll_data  = ~r_crc[7:0];
                if (tx.ll_ack) w_state_nxt = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                tx.ll_valid = 1'b1;
                tx.ll_data  = ~r_crc[15:8];
                tx.ll_last  = 1'b1;
                if (tx.ll_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign tx.pkt_done = r_done;
    assign tx.busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_usb_tx_pkt.sv
// Directed bench for usb_tx_pkt: handshake PIDs, ZLP, known-CRC payload, stalls, reset and back-to-back.
module tb_usb_tx_pkt;
    import usb_tx_pkt_pkg::*;

    localparam int LEN_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_pkt_if #(.LEN_W(LEN_W)) tx ();
    usb_tx_pkt #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .tx(tx));

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int idx      = 0;
    int ack_cnt, done_cnt, gap_cnt, last_acc_cyc;
    bit rand_ack = 1'b0;
    bit inject   = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    logic [7:0] payload [0:1023];
    logic [7:0] got_b[$];
    logic       got_l[$];
    logic [7:0] exp_b[$];
    logic       exp_l[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then drive the next inputs 1ns after posedge.
    task automatic tick();
        logic start_seen, ack_seen;
        @(negedge clk);
        cycle++;
        start_seen = tx.pkt_start & ~tx.busy;
        ack_seen   = tx.pkt_data_ack;
        if (ack_seen) ack_cnt++;
        if (tx.busy && !tx.ll_valid) gap_cnt++;
        if (prev_stall && tx.ll_valid) begin
            chk("stall_data", tx.ll_data, prev_data);
            chk("stall_last", tx.ll_last, prev_last);
        end
        prev_stall = tx.ll_valid & ~tx.ll_ack;
        prev_data  = tx.ll_data;
        prev_last  = tx.ll_last;
        if (tx.ll_valid && tx.ll_ack) begin
            got_b.push_back(tx.ll_data);
            got_l.push_back(tx.ll_last);
            if (tx.ll_last) last_acc_cyc = cycle;
        end
        if (tx.pkt_done) begin
            done_cnt++;
            chk("done_latency", cycle, last_acc_cyc + 1);
            chk("done_busy", tx.busy, 1'b0);
        end
        @(posedge clk);
        #1;
        tx.pkt_start = 1'b0;
        if (start_seen) begin
            idx = 0;
            tx.pkt_data = payload[0];
        end else if (ack_seen) begin
            idx++;
            tx.pkt_data = payload[idx];
        end
        tx.ll_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inject && tx.busy && $urandom_range(0, 3) == 0) begin
            tx.pkt_start = 1'b1;
            tx.pkt_pid   = PID_ACK;
            tx.pkt_len   = LEN_W'(5);
        end
    endtask

    task automatic start_pkt(input logic [3:0] pid, input int len);
        tx.pkt_pid   = pid;
        tx.pkt_len   = LEN_W'(len);
        tx.pkt_start = 1'b1;
    endtask

    task automatic clear_log();
        got_b.delete(); got_l.delete(); exp_b.delete(); exp_l.delete();
        ack_cnt = 0; done_cnt = 0; gap_cnt = 0; last_acc_cyc = -10;
    endtask

    task automatic wait_done(input string tag, input int n);
        int budget = 3000;
        while (done_cnt < n && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_done_cnt"}, done_cnt, n);
    endtask

    // Bit-serial reference CRC over payload[0..len-1].
    function automatic logic [15:0] model_crc(input int len);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ payload[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic add_exp(input logic [3:0] pid, input int len);
        logic [15:0] c;
        exp_b.push_back({~pid, pid});
        exp_l.push_back(pid[1:0] != 2'b11);
        if (pid[1:0] == 2'b11) begin
            for (int i = 0; i < len; i++) begin
                exp_b.push_back(payload[i]);
                exp_l.push_back(1'b0);
            end
            c = ~model_crc(len);
            exp_b.push_back(c[7:0]);  exp_l.push_back(1'b0);
            exp_b.push_back(c[15:8]); exp_l.push_back(1'b1);
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_nbytes"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
        end
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 1024; i++) payload[i] = 8'h00;
        tx.pkt_start = 1'b0;
        tx.pkt_pid   = 4'h0;
        tx.pkt_len   = '0;
        tx.pkt_data  = 8'h00;
        tx.ll_ack    = 1'b1;
        rst = 1'b1;

        // Reset state
        @(posedge clk); #1;
        chk("rst_ll_valid", tx.ll_valid, 1'b0);
        chk("rst_ll_last", tx.ll_last, 1'b0);
        chk("rst_busy", tx.busy, 1'b0);
        chk("rst_pkt_done", tx.pkt_done, 1'b0);
        chk("rst_data_ack", tx.pkt_data_ack, 1'b0);
        chk("rst_ll_data", tx.ll_data, 8'h00);
        rst = 1'b0;
        tick();

        // ACK handshake
        clear_log();
        add_exp(PID_ACK, 0);
        start_pkt(PID_ACK, 0);
        wait_done("ack", 1);
        check_stream("ack");
        chk("ack_byte_hand", got_b[0], 8'hD2);
        chk("ack_data_ack", ack_cnt, 0);
        tick();

        // DATA0 zero-length packet
        clear_log();
        add_exp(PID_DATA0, 0);
        start_pkt(PID_DATA0, 0);
        wait_done("zlp", 1);
        check_stream("zlp");
        chk("zlp_b0_hand", got_b[0], 8'hC3);
        chk("zlp_b1_hand", got_b[1], 8'h00);
        chk("zlp_b2_hand", got_b[2], 8'h00);
        chk("zlp_data_ack", ack_cnt, 0);

        // DATA1 "123456789" -> CRC 0xB4C8
        clear_log();
        for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
        add_exp(PID_DATA1, 9);
        start_pkt(PID_DATA1, 9);
        wait_done("d1", 1);
        check_stream("d1");
        chk("d1_pid_hand", got_b[0], 8'h4B);
        chk("d1_crclo_hand", got_b[10], 8'hC8);
        chk("d1_crchi_hand", got_b[11], 8'hB4);
        chk("d1_data_ack", ack_cnt, 9);
        chk("d1_fetch_gaps", gap_cnt, 8);

        // 64-byte DATA0 with random stalls and ignored starts while busy
        clear_log();
        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom_range(0, 255));
        add_exp(PID_DATA0, 64);
        rand_ack = 1'b1;
        inject   = 1'b1;
        start_pkt(PID_DATA0, 64);
        wait_done("stall", 1);
        rand_ack = 1'b0;
        inject   = 1'b0;
        tx.ll_ack = 1'b1;
        check_stream("stall");
        chk("stall_data_ack", ack_cnt, 64);
        tick();
        tick();
        chk("stall_no_extra_done", done_cnt, 1);
        chk("stall_idle_after", tx.busy, 1'b0);

        // Reset in mid-payload of a 20-byte packet
        clear_log();
        for (int i = 0; i < 20; i++) payload[i] = 8'hA0 + 8'(i);
        start_pkt(PID_DATA0, 20);
        budget = 200;
        while (!(ack_cnt >= 5 && tx.ll_valid) && budget > 0) begin
            tick();
            budget--;
        end
        chk("rst_mid_pre_valid", tx.ll_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", tx.ll_valid, 1'b0);
        chk("rst_mid_busy", tx.busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_mid_no_done", done_cnt, 0);

        clear_log();
        add_exp(PID_NAK, 0);
        start_pkt(PID_NAK, 0);
        wait_done("nak", 1);
        check_stream("nak");
        chk("nak_byte_hand", got_b[0], 8'h5A);

        // Back-to-back: DATA0 len=1 started in the cycle of the ACK's pkt_done
        clear_log();
        payload[0] = 8'h55;
        add_exp(PID_ACK, 0);
        add_exp(PID_DATA0, 1);
        start_pkt(PID_ACK, 0);
        budget = 50;
        tick();
        while (!tx.pkt_done && budget > 0) begin
            tick();
            budget--;
        end
        chk("b2b_first_done", tx.pkt_done, 1'b1);
        start_pkt(PID_DATA0, 1);
        wait_done("b2b", 2);
        check_stream("b2b");
        chk("b2b_data_ack", ack_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
